// File: rtl/regfile_scan_checker.sv
// regfile_scan_checker
//   Self-check engine placed between a processor's read-A address and its
//   regfile. It lets the processor run for a programmable number of cycles,
//   logs every architectural register write seen in that window, then takes
//   over the read-A port. It sweeps all registers and compares each one with
//   an expected-value memory. Mismatches are counted and reported.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               1-cycle pulse, begins a run (honoured in IDLE/DONE only)
//   i_num_cycles          run length, sampled on the start cycle
//   i_proc_rwe/rd/wdata   monitored processor regfile write port
//   i_proc_rs1            processor read-A address
//   o_rs1_out             read-A address to regfile (i_proc_rs1 or scan index)
//   i_reg_data            regfile read-A data (combinational from o_rs1_out)
//   o_exp_addr            expected-memory address
//   i_exp_data            expected data, 1-cycle read latency
//   o_busy/o_test_mode    RUN or SCAN / SCAN only
//   o_done/o_pass         DONE / DONE with zero errors
//   o_err_count           saturating mismatch counter
//   o_log_*               registered report of a processor write during RUN
//   o_fail_*              registered report of a scan mismatch
module regfile_scan_checker #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CYC_W    = 16,
  parameter int unsigned ERR_W    = 8,
  parameter bit          SKIP_R0  = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [CYC_W-1:0]  i_num_cycles,
  input  logic              i_proc_rwe,
  input  logic [ADDR_W-1:0] i_proc_rd,
  input  logic [DATA_W-1:0] i_proc_wdata,
  input  logic [ADDR_W-1:0] i_proc_rs1,
  output logic [ADDR_W-1:0] o_rs1_out,
  input  logic [DATA_W-1:0] i_reg_data,
  output logic [ADDR_W-1:0] o_exp_addr,
  input  logic [DATA_W-1:0] i_exp_data,
  output logic              o_busy,
  output logic              o_test_mode,
  output logic              o_done,
  output logic              o_pass,
  output logic [ERR_W-1:0]  o_err_count,
  output logic              o_log_valid,
  output logic [CYC_W-1:0]  o_log_cycle,
  output logic [ADDR_W-1:0] o_log_reg,
  output logic [DATA_W-1:0] o_log_data,
  output logic              o_fail_valid,
  output logic [ADDR_W-1:0] o_fail_reg,
  output logic [DATA_W-1:0] o_fail_exp,
  output logic [DATA_W-1:0] o_fail_act
);

  // One extra bit so the index can reach NUM_REGS (the drain cycle).
  localparam int unsigned IDX_W = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StScan, StDone} state_e;

  state_e            r_state;
  logic [CYC_W-1:0]  r_cyc;
  logic [CYC_W-1:0]  r_num;
  logic [IDX_W-1:0]  r_idx;
  logic [ERR_W-1:0]  r_err;
  logic [DATA_W-1:0] r_cap;
  logic [ADDR_W-1:0] r_cap_idx;
  logic              r_cap_vld;
  logic              r_log_valid;
  logic [CYC_W-1:0]  r_log_cycle;
  logic [ADDR_W-1:0] r_log_reg;
  logic [DATA_W-1:0] r_log_data;
  logic              r_fail_valid;
  logic [ADDR_W-1:0] r_fail_reg;
  logic [DATA_W-1:0] r_fail_exp;
  logic [DATA_W-1:0] r_fail_act;

  logic              w_scan;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_mismatch;
  logic              w_run_last;

  assign w_scan      = (r_state == StScan);
  assign w_scan_addr = r_idx[ADDR_W-1:0];

  // Stage 1: value captured last cycle against expected data for the same index.
  assign w_mismatch = r_cap_vld && (r_cap != i_exp_data) &&
                      !(SKIP_R0 && (r_cap_idx == '0));

  // num_cycles == 0 still spends one RUN cycle, but nothing in it is logged.
  assign w_run_last = (r_num == '0) || ((r_cyc + CYC_W'(1)) == r_num);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cyc        <= '0;
      r_num        <= '0;
      r_idx        <= '0;
      r_err        <= '0;
      r_cap        <= '0;
      r_cap_idx    <= '0;
      r_cap_vld    <= 1'b0;
      r_log_valid  <= 1'b0;
      r_log_cycle  <= '0;
      r_log_reg    <= '0;
      r_log_data   <= '0;
      r_fail_valid <= 1'b0;
      r_fail_reg   <= '0;
      r_fail_exp   <= '0;
      r_fail_act   <= '0;
    end else begin
      r_log_valid  <= 1'b0;
      r_fail_valid <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state   <= StRun;
            r_cyc     <= '0;
            r_err     <= '0;
            r_idx     <= '0;
            r_cap_vld <= 1'b0;
            r_num     <= i_num_cycles;
          end
        end
        StRun: begin
          r_cyc <= r_cyc + CYC_W'(1);
          if ((r_num != '0) && i_proc_rwe && (i_proc_rd != '0)) begin
            r_log_valid <= 1'b1;
            r_log_cycle <= r_cyc;
            r_log_reg   <= i_proc_rd;
            r_log_data  <= i_proc_wdata;
          end
          if (w_run_last) begin
            r_state <= StScan;
          end
        end
        StScan: begin
          // Stage 0: capture regfile data for the current index.
          if (r_idx < IDX_W'(NUM_REGS)) begin
            r_cap     <= i_reg_data;
            r_cap_idx <= w_scan_addr;
            r_cap_vld <= 1'b1;
            r_idx     <= r_idx + IDX_W'(1);
          end else begin
            r_cap_vld <= 1'b0;
          end
          if (w_mismatch) begin
            r_fail_valid <= 1'b1;
            r_fail_reg   <= r_cap_idx;
            r_fail_exp   <= i_exp_data;
            r_fail_act   <= r_cap;
            if (r_err != '1) begin
              r_err <= r_err + ERR_W'(1);
            end
          end
          // Drain cycle holds the compare of the last index.
          if (r_idx == IDX_W'(NUM_REGS)) begin
            r_state <= StDone;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rs1_out    = w_scan ? w_scan_addr : i_proc_rs1;
  assign o_exp_addr   = w_scan ? w_scan_addr : '0;
  assign o_busy       = (r_state == StRun) || w_scan;
  assign o_test_mode  = w_scan;
  assign o_done       = (r_state == StDone);
  assign o_pass       = (r_state == StDone) && (r_err == '0);
  assign o_err_count  = r_err;
  assign o_log_valid  = r_log_valid;
  assign o_log_cycle  = r_log_cycle;
  assign o_log_reg    = r_log_reg;
  assign o_log_data   = r_log_data;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_reg   = r_fail_reg;
  assign o_fail_exp   = r_fail_exp;
  assign o_fail_act   = r_fail_act;

endmodule
